truth_table_sweeper: RTL and testbench

- Sequencer that exercises one 3-input combinational logic gate, such as the wolfram 0x2A function block.
- Steps the gate's inputs through every input combination, waits a settle interval, samples the output several times and majority-votes each row.
- Assembles the measured truth table, compares it against an expected code, and reports match plus a per-row mismatch mask.
- Sits between a test/config host and the gate: characterises and self-checks slow or noisy circuit models.

---
 rtl/truth_table_sweeper_pkg.sv | 23 ++
 rtl/truth_table_sweeper_if.sv | 31 +++
 rtl/truth_table_sweeper_sample_vote.sv | 33 +++
 rtl/truth_table_sweeper.sv | 147 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types, sizes and helpers for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_sweeper_pkg;

   localparam int N_IN = 3;
   localparam int ROWS = 1 << N_IN;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE,
      COMMIT,
      DONE
   } sweep_state_t;

   // Row 000 lands in the MSB of the table, so the bit index is mirrored.
   function automatic logic [N_IN-1:0] row_bit(input logic [N_IN-1:0] r);
      return N_IN'(ROWS - 1) - r;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Host/gate bundle for the truth-table sweeper.
// Latency: n/a (wires only).
// Backpressure: none; start is a request sampled only while idle.
// Ports: start/abort from the host, dut_in/dut_out to the gate under test,
// busy/done/table_o/match/mismatch_mask status back to the host.
interface truth_table_sweeper_if;
   import truth_table_sweeper_pkg::*;

   logic            start;
   logic            abort;
   logic [N_IN-1:0] dut_in;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic [ROWS-1:0] table_o;
   logic            match;
   logic [ROWS-1:0] mismatch_mask;

   // Host and gate side.
   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, table_o, match, mismatch_mask
   );

   // Sweeper side.
   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, table_o, match, mismatch_mask
   );

endinterface

// File: rtl/truth_table_sweeper_sample_vote.sv
// Counts ones on a sampled bit and reports the majority over SAMPLES samples.
// Latency: majority reflects samples taken up to the previous edge.
// Backpressure: none; caller controls clr/en.
// Ports: clk, rst_n, clr (zero count), en (sample bit_in), bit_in, majority.
module truth_table_sweeper_sample_vote #(
   parameter int SAMPLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic majority
);

   localparam int CNT_W = $clog2(SAMPLES + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && bit_in) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // SAMPLES is odd, so strictly more than half is an unambiguous majority.
   assign majority = (cnt > CNT_W'(SAMPLES / 2));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input gate through all rows, majority-votes its output, checks the table.
// Latency: done pulses ROWS*(SETTLE_CYCLES+SAMPLES+2) cycles after start is accepted.
// Backpressure: start ignored while busy (not queued); abort returns to idle next edge.
// Ports: clk, rst_n, bus (slave side: start/abort/dut_out in; dut_in/status out).
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int              SETTLE_CYCLES = 4,
   parameter int              SAMPLES       = 3,
   parameter logic [ROWS-1:0] EXPECTED      = 8'h2A
) (
   input  logic                  clk,
   input  logic                  rst_n,
   truth_table_sweeper_if.slave  bus
);

   // One phase counter serves both SETTLE and SAMPLE.
   localparam int CYC_MAX = ((SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES) - 1;
   localparam int CYC_W   = (CYC_MAX > 0) ? $clog2(CYC_MAX + 1) : 1;

   sweep_state_t    state, state_nxt;
   logic [CYC_W-1:0] cyc;
   logic [N_IN-1:0] row, row_nxt;
   logic [ROWS-1:0] scratch, scratch_nxt;
   logic            last_row;
   logic            vote_clr, vote_en, vote_maj;

   logic [N_IN-1:0] dut_in_q;
   logic            done_q;
   logic [ROWS-1:0] table_q;
   logic            match_q;
   logic [ROWS-1:0] mask_q;

   truth_table_sweeper_sample_vote #(
      .SAMPLES (SAMPLES)
   ) u_vote (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (vote_clr),
      .en       (vote_en),
      .bit_in   (bus.dut_out),
      .majority (vote_maj)
   );

   assign last_row = (row == N_IN'(ROWS - 1));

   always_comb begin
      state_nxt   = state;
      vote_clr    = 1'b0;
      vote_en     = 1'b0;
      row_nxt     = '0;
      scratch_nxt = scratch;
      scratch_nxt[row_bit(row)] = vote_maj;

      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            vote_clr  = 1'b1;
            state_nxt = SETTLE;
         end
         SETTLE: begin
            if (cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
               state_nxt = SAMPLE;
            end
         end
         SAMPLE: begin
            vote_en = 1'b1;
            if (cyc == CYC_W'(SAMPLES - 1)) begin
               state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            row_nxt   = row + N_IN'(1);
            state_nxt = last_row ? DONE : APPLY;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // DONE is the point of no return; the results are already latched.
      if (bus.abort && (state != IDLE) && (state != DONE)) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cyc      <= '0;
         row      <= '0;
         scratch  <= '0;
         dut_in_q <= '0;
         done_q   <= 1'b0;
         table_q  <= '0;
         match_q  <= 1'b0;
         mask_q   <= '0;
      end else begin
         state <= state_nxt;

         if ((state_nxt != state) || (state_nxt == IDLE)) begin
            cyc <= '0;
         end else begin
            cyc <= cyc + CYC_W'(1);
         end

         // dut_in is loaded on entry to APPLY so the row is on the gate for
         // the whole APPLY..COMMIT window.
         if (state_nxt == APPLY) begin
            row      <= row_nxt;
            dut_in_q <= row_nxt;
         end else if (state_nxt == IDLE) begin
            row      <= '0;
            dut_in_q <= '0;
         end

         if ((state == IDLE) && (state_nxt == APPLY)) begin
            scratch <= '0;
         end else if (state == COMMIT) begin
            scratch <= scratch_nxt;
         end

         // Results latch on the edge into DONE so they are valid with done.
         done_q <= (state == COMMIT) && (state_nxt == DONE);
         if ((state == COMMIT) && (state_nxt == DONE)) begin
            table_q <= scratch_nxt;
            match_q <= (scratch_nxt == EXPECTED);
            mask_q  <= scratch_nxt ^ EXPECTED;
         end
      end
   end

   assign bus.dut_in        = dut_in_q;
   assign bus.busy          = (state != IDLE);
   assign bus.done          = done_q;
   assign bus.table_o       = table_q;
   assign bus.match         = match_q;
   assign bus.mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: vector table of gate models with a result scoreboard,
// plus abort, ignored-start, abort-in-DONE and async-reset sequences.
// Ports: none (top-level bench).
module tb_truth_table_sweeper;
   import truth_table_sweeper_pkg::*;

   typedef struct {
      logic [1:0] gsel;
      bit         glitch;
      logic [7:0] tbl;
      bit         mt;
      logic [7:0] mask;
   } vec_t;

   logic clk;
   logic rst_n;
   int   cyc;
   logic [1:0] gate_sel;
   bit   glitch_en;

   int total;
   int bad;

   vec_t vecs[5];
   vec_t sb[$];
   logic [7:0] last_tbl;
   bit         last_match;
   logic [7:0] last_mask;

   truth_table_sweeper_if bus ();

   truth_table_sweeper dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic gate(input logic [1:0] sel, input logic [2:0] x);
      case (sel)
         2'd0:    return (x[2] | x[1]) & ~x[0];
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return ^x;
      endcase
   endfunction

   // Glitch on one of three samples of row 000 (cycle 5) and dropout on one
   // of three samples of row 010 (cycle 24).
   assign bus.dut_out = gate(gate_sel, bus.dut_in) ^ (glitch_en && (cyc == 5 || cyc == 24));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_sweep(input vec_t v, input int abort_cyc, input bit ghost);
      bit   aborting;
      int   done_cnt;
      int   done_at;
      int   end_at;
      vec_t e;
      aborting = (abort_cyc >= 0) && (abort_cyc < 72);
      done_cnt = 0;
      done_at  = -1;
      end_at   = -1;
      gate_sel  = v.gsel;
      glitch_en = v.glitch;
      if (!aborting) sb.push_back(v);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      chk("busy_after_start", int'(bus.busy), 1);

      for (int k = 0; k < 150; k++) begin
         bus.abort = (cyc == abort_cyc);
         bus.start = ghost && (cyc == 10 || cyc == 40);
         tick();
         bus.abort = 1'b0;
         bus.start = 1'b0;
         if (bus.done) begin
            done_cnt++;
            done_at = cyc;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
               e = sb.pop_front();
               chk("table_o", int'(bus.table_o), int'(e.tbl));
               chk("match", int'(bus.match), int'(e.mt));
               chk("mismatch_mask", int'(bus.mismatch_mask), int'(e.mask));
               last_tbl   = e.tbl;
               last_match = e.mt;
               last_mask  = e.mask;
            end
         end
         if (cyc == 29) chk("dut_in_row3", int'(bus.dut_in), 3);
         if (cyc == 36) chk("table_stable_mid", int'(bus.table_o), int'(last_tbl));
         if (!bus.busy) begin
            end_at = cyc;
            break;
         end
      end

      if (end_at < 0) begin
         total++;
         bad++;
         $display("FAIL sweep_timeout: busy still 1 after 150 cycles, expected idle");
      end
      chk("end_cycle", end_at, aborting ? abort_cyc + 1 : 73);
      chk("done_count", done_cnt, aborting ? 0 : 1);
      if (!aborting) chk("done_cycle", done_at, 72);
      chk("dut_in_idle", int'(bus.dut_in), 0);
      chk("table_kept", int'(bus.table_o), int'(last_tbl));
      chk("match_kept", int'(bus.match), int'(last_match));
      chk("mask_kept", int'(bus.mismatch_mask), int'(last_mask));
      glitch_en = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      gate_sel = 2'd0;
      glitch_en = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      last_tbl = 8'h00;
      last_match = 1'b0;
      last_mask = 8'h00;

      vecs[0] = '{2'd0, 1'b0, 8'h2A, 1'b1, 8'h00};
      vecs[1] = '{2'd1, 1'b0, 8'h00, 1'b0, 8'h2A};
      vecs[2] = '{2'd2, 1'b0, 8'hFF, 1'b0, 8'hD5};
      vecs[3] = '{2'd3, 1'b0, 8'h69, 1'b0, 8'h43};
      vecs[4] = '{2'd0, 1'b1, 8'h2A, 1'b1, 8'h00};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_table", int'(bus.table_o), 0);
      chk("rst_match", int'(bus.match), 0);
      chk("rst_mask", int'(bus.mismatch_mask), 0);
      chk("rst_dut_in", int'(bus.dut_in), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // start and abort together in IDLE: abort wins.
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      tick();
      chk("start_abort_idle", int'(bus.busy), 0);

      for (int i = 0; i < 5; i++) begin
         run_sweep(vecs[i], -1, 1'b0);
      end

      // Abort mid-sweep keeps the previous 0x2A results.
      run_sweep(vecs[1], 30, 1'b0);
      // Starts while busy are ignored.
      run_sweep(vecs[0], -1, 1'b1);
      // Abort while in DONE does not stop completion.
      run_sweep(vecs[3], 72, 1'b0);

      // Asynchronous reset mid-sweep.
      gate_sel = 2'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cyc = 0;
      repeat (20) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_table", int'(bus.table_o), 0);
      chk("arst_match", int'(bus.match), 0);
      chk("arst_mask", int'(bus.mismatch_mask), 0);
      chk("arst_dut_in", int'(bus.dut_in), 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_tbl = 8'h00;
      last_match = 1'b0;
      last_mask = 8'h00;
      @(negedge clk);
      run_sweep(vecs[0], -1, 1'b0);

      chk("scoreboard_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
